// File: rtl/full_adder.sv
// Registered ripple-carry adder: one full-adder cell per bit, one-cycle latency,
// with carry-out, two's-complement overflow and zero flags.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid,
  output logic             ovf,
  output logic             zero
);

  // Single-bit cell, returns {carry_out, sum}.
  function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             zero_s;

  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             out_valid_r;
  logic             ovf_r;
  logic             zero_r;

  // Ripple the carry from cin through every cell and derive the flags.
  always_comb begin
    carry_s    = {(WIDTH + 1){1'b0}};
    sum_s      = {WIDTH{1'b0}};
    carry_s[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      {carry_s[i+1], sum_s[i]} = fa_cell(a[i], b[i], carry_s[i]);
    end
    ovf_s  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
    zero_s = (sum_s == {WIDTH{1'b0}});
  end

  // Result registers; operands are captured only when in_valid is high, so
  // unknown operands while idle never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r         <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        s_r    <= sum_s;
        cout_r <= carry_s[WIDTH];
        ovf_r  <= ovf_s;
        zero_r <= zero_s;
      end
    end
  end

  assign s         = s_r;
  assign cout      = cout_r;
  assign out_valid = out_valid_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=4 against an arithmetic
// reference model (integer sum, signed range check for overflow).
module tb_full_adder;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1, ovf1, z1;
  logic       v4, c4;
  logic [3:0] a4, b4;
  logic [3:0] s4;
  logic       co4, ov4, ovf4, z4;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .s(s1), .cout(co1), .out_valid(ov1), .ovf(ovf1), .zero(z1)
  );

  full_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .s(s4), .cout(co4), .out_valid(ov4), .ovf(ovf4), .zero(z4)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   ov4_cnt     = 0;
  exp_t q1[$];
  exp_t q4[$];

  // Reference: plain integer addition; overflow when the signed sum leaves the
  // representable range of a w-bit two's-complement number.
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic cin);
    exp_t        e;
    logic [64:0] full;
    longint      sa, sb, r, lim;
    full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    e.s    = full[63:0] & ((64'd1 << w) - 64'd1);
    e.cout = full[w];
    lim    = longint'(1) << (w - 1);
    sa     = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
    sb     = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
    r      = sa + sb + (cin ? longint'(1) : longint'(0));
    e.ovf  = (r >= lim) || (r < -lim);
    e.zero = (e.s == 64'd0);
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus side of the scoreboard: record what each accepted operand must produce.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (v1 === 1'b1) q1.push_back(model(1, 64'(a1), 64'(b1), c1));
      if (v4 === 1'b1) q4.push_back(model(4, 64'(a4), 64'(b4), c4));
    end
  end

  // Anything in flight at reset is discarded.
  always @(posedge rst) begin
    q1.delete();
    q4.delete();
  end

  // Monitor: compare every presented result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL u1 unexpected out_valid: got 1 expected 0");
      end else begin
        e = q1.pop_front();
        chk("u1 s", 64'(s1), e.s);
        chk("u1 cout", 64'(co1), 64'(e.cout));
        chk("u1 ovf", 64'(ovf1), 64'(e.ovf));
        chk("u1 zero", 64'(z1), 64'(e.zero));
      end
    end
    if (ov4 === 1'b1) begin
      ov4_cnt++;
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL u4 unexpected out_valid: got 1 expected 0");
      end else begin
        e = q4.pop_front();
        chk("u4 s", 64'(s4), e.s);
        chk("u4 cout", 64'(co4), 64'(e.cout));
        chk("u4 ovf", 64'(ovf4), 64'(e.ovf));
        chk("u4 zero", 64'(z4), 64'(e.zero));
      end
    end
  end

  task automatic drive1(logic v, logic a, logic b, logic c);
    @(posedge clk);
    #2;
    v1 = v; a1 = a; b1 = b; c1 = c;
  endtask

  task automatic drive4(logic v, logic [3:0] a, logic [3:0] b, logic c);
    @(posedge clk);
    #2;
    v4 = v; a4 = a; b4 = b; c4 = c;
  endtask

  initial begin
    int cnt0;
    int ix;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;

    #3;
    chk("reset u1 s", 64'(s1), 64'd0);
    chk("reset u1 out_valid", 64'(ov1), 64'd0);
    chk("reset u1 zero", 64'(z1), 64'd0);
    chk("reset u4 s", 64'(s4), 64'd0);
    chk("reset u4 cout", 64'(co4), 64'd0);
    chk("reset u4 ovf", 64'(ovf4), 64'd0);
    chk("reset u4 zero", 64'(z4), 64'd0);
    chk("reset u4 out_valid", 64'(ov4), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // WIDTH=1: all eight combinations back-to-back, then directed spot checks.
    for (int i = 0; i < 8; i++) begin
      ix = i;
      drive1(1'b1, ix[2], ix[1], ix[0]);
    end
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("w1 111 s", 64'(s1), 64'd1);
    chk("w1 111 cout", 64'(co1), 64'd1);
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("w1 100 s", 64'(s1), 64'd1);
    chk("w1 100 cout", 64'(co1), 64'd0);
    drive1(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("w1 000 s", 64'(s1), 64'd0);
    chk("w1 000 zero", 64'(z1), 64'd1);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive1(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      else
        drive1(1'b0, 1'bx, 1'bx, 1'bx);
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=4 ripple corners.
    drive4(1'b1, 4'hF, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("w4 F+0+1 s", 64'(s4), 64'h0);
    chk("w4 F+0+1 cout", 64'(co4), 64'd1);
    chk("w4 F+0+1 zero", 64'(z4), 64'd1);
    chk("w4 F+0+1 ovf", 64'(ovf4), 64'd0);
    drive4(1'b1, 4'h7, 4'h1, 1'b0);
    @(posedge clk); #1;
    chk("w4 7+1 s", 64'(s4), 64'h8);
    chk("w4 7+1 cout", 64'(co4), 64'd0);
    chk("w4 7+1 ovf", 64'(ovf4), 64'd1);
    drive4(1'b0, 4'hx, 4'hx, 1'bx);
    @(posedge clk);

    // Back-to-back burst: one result per cycle, no bubbles.
    cnt0 = ov4_cnt;
    for (int i = 0; i < 20; i++)
      drive4(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
    drive4(1'b0, 4'hx, 4'hx, 1'bx);
    @(posedge clk);
    @(posedge clk); #1;
    chk("w4 burst result count", 64'(ov4_cnt - cnt0), 64'd20);

    // Hold: idle cycle with unknown operands keeps the last result.
    drive4(1'b1, 4'h3, 4'h4, 1'b0);
    drive4(1'b0, 4'hx, 4'hx, 1'bx);
    chk("hold s before", 64'(s4), 64'h7);
    chk("hold out_valid before", 64'(ov4), 64'd1);
    @(posedge clk); #1;
    chk("hold s", 64'(s4), 64'h7);
    chk("hold out_valid", 64'(ov4), 64'd0);

    // Asynchronous reset while s=A with another operand pending.
    drive4(1'b1, 4'h5, 4'h5, 1'b0);
    drive4(1'b1, 4'h1, 4'h2, 1'b0);
    chk("pre-reset s", 64'(s4), 64'hA);
    #1 rst = 1'b1;
    #1;
    chk("async reset s", 64'(s4), 64'h0);
    chk("async reset out_valid", 64'(ov4), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    v4  = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("post-reset out_valid", 64'(ov4), 64'd0);
    chk("post-reset s", 64'(s4), 64'h0);

    // Random WIDTH=4 traffic with idle gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive4(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
      else
        drive4(1'b0, 4'hx, 4'hx, 1'bx);
    end
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("u1 results outstanding", 64'(q1.size()), 64'd0);
    chk("u4 results outstanding", 64'(q4.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
